// File: rtl/adc_responder.sv
// rtl/adc_responder.sv - LTC2308-style 4-wire ADC serial responder backed by an 8-entry channel register file.
// Optional feature macro: ADC_RESP_BIPOLAR_EN (invert bit 11 of the loaded sample when cfg_uni=0).
module adc_responder #(
   parameter int SCK_MIN_HALF = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ADC_CONVST,
   input  logic        ADC_SCK,
   input  logic        ADC_SDI,
   output logic        ADC_SDO,
   input  logic        wr_en,
   input  logic [2:0]  wr_chan,
   input  logic [11:0] wr_data,
   output logic [2:0]  cfg_chan,
   output logic        cfg_uni,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   // Two sync stages plus one edge-detect stage; shorter SCK phases cannot be tracked.
   if (SCK_MIN_HALF < 2) begin : g_half_chk
      $error("adc_responder: SCK_MIN_HALF must be at least 2");
   end

   state_t      state_q, state_d;
   logic [2:0]  conv_sync, sck_sync;
   logic [1:0]  sdi_sync;
   logic        conv_rise, conv_fall, sck_rise, sck_fall;
   logic        last_fall;
   logic        load_q;
   logic [11:0] regs [8];
   logic [11:0] shift_out;
   logic [11:0] load_val;
   logic [3:0]  shift_in;
   logic [2:0]  bit_cnt_in;
   logic [3:0]  bit_cnt_out;

   assign conv_rise = conv_sync[1] & ~conv_sync[2];
   assign conv_fall = ~conv_sync[1] & conv_sync[2];
   assign sck_rise  = sck_sync[1] & ~sck_sync[2];
   assign sck_fall  = ~sck_sync[1] & sck_sync[2];

`ifdef ADC_RESP_BIPOLAR_EN
   assign load_val = cfg_uni ? regs[cfg_chan] : (regs[cfg_chan] ^ 12'h800);
`else
   assign load_val = regs[cfg_chan];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         conv_sync <= '0;
         sck_sync  <= '0;
         sdi_sync  <= '0;
      end else begin
         conv_sync <= {conv_sync[1:0], ADC_CONVST};
         sck_sync  <= {sck_sync[1:0], ADC_SCK};
         sdi_sync  <= {sdi_sync[0], ADC_SDI};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_fall = 1'b0;
      if (conv_rise) begin
         state_d = CONV;
      end else begin
         case (state_q)
            CONV: begin
               if (conv_fall) begin
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (sck_fall && bit_cnt_out == 4'd11) begin
                  state_d   = IDLE;
                  last_fall = 1'b1;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
         shift_out   <= '0;
         shift_in    <= '0;
         bit_cnt_in  <= '0;
         bit_cnt_out <= '0;
         load_q      <= 1'b0;
         ADC_SDO     <= 1'b0;
         cfg_chan    <= '0;
         cfg_uni     <= 1'b1;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= last_fall;
         load_q     <= conv_rise;
         if (wr_en) begin
            regs[wr_chan] <= wr_data;
         end
         if (load_q) begin
            ADC_SDO <= shift_out[11];
         end
         if (conv_rise) begin
            shift_out   <= load_val;
            shift_in    <= '0;
            bit_cnt_in  <= '0;
            bit_cnt_out <= '0;
         end else if (state_q == SHIFT) begin
            if (sck_rise && bit_cnt_in < 3'd6) begin
               // S/D falls out the top; on the 6th bit the register holds O/S,S1,S0,UNI and SDI is SLP.
               shift_in   <= {shift_in[2:0], sdi_sync[1]};
               bit_cnt_in <= bit_cnt_in + 3'd1;
               if (bit_cnt_in == 3'd5) begin
                  cfg_chan <= {shift_in[2], shift_in[1], shift_in[3]};
                  cfg_uni  <= shift_in[0];
               end
            end
            if (sck_fall) begin
               shift_out   <= {shift_out[10:0], 1'b0};
               ADC_SDO     <= shift_out[10];
               bit_cnt_out <= bit_cnt_out + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_responder.sv
// tb/tb_adc_responder.sv - Scoreboard bench for adc_responder frames, config pipelining, aborts and writes.
module tb_adc_responder;
   localparam int HALF = 6;
`ifdef ADC_RESP_BIPOLAR_EN
   localparam logic [11:0] BIP_EXP = 12'h000;
`else
   localparam logic [11:0] BIP_EXP = 12'h800;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ADC_CONVST = 1'b0;
   logic        ADC_SCK = 1'b0;
   logic        ADC_SDI = 1'b0;
   logic        ADC_SDO;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_chan = '0;
   logic [11:0] wr_data = '0;
   logic [2:0]  cfg_chan;
   logic        cfg_uni;
   logic        frame_done;

   int n_checks = 0;
   int n_pass = 0;
   int done_cnt = 0;
   int d0;
   logic [11:0] m_regs [8];
   logic [2:0]  m_chan;
   logic        m_uni;
   logic [11:0] exp_q [$];
   logic [15:0] bits;

   always #5 clk = ~clk;

   adc_responder #(.SCK_MIN_HALF(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .ADC_CONVST (ADC_CONVST),
      .ADC_SCK    (ADC_SCK),
      .ADC_SDI    (ADC_SDI),
      .ADC_SDO    (ADC_SDO),
      .wr_en      (wr_en),
      .wr_chan    (wr_chan),
      .wr_data    (wr_data),
      .cfg_chan   (cfg_chan),
      .cfg_uni    (cfg_uni),
      .frame_done (frame_done)
   );

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [11:0] m_value();
      logic [11:0] v;
      v = m_regs[m_chan];
`ifdef ADC_RESP_BIPOLAR_EN
      if (!m_uni) v[11] = ~v[11];
`endif
      return v;
   endfunction

   task automatic write_reg(input logic [2:0] ch, input logic [11:0] val);
      @(negedge clk);
      wr_en = 1'b1; wr_chan = ch; wr_data = val;
      @(negedge clk);
      wr_en = 1'b0;
      m_regs[ch] = val;
   endtask

   // collide=1 writes cdata to the selected channel in the cycle the synced CONVST edge is acted on.
   task automatic start_frame(input bit push, input bit collide, input logic [11:0] cdata);
      if (push) exp_q.push_back(m_value());
      @(negedge clk);
      ADC_CONVST = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (collide) begin
         wr_en = 1'b1; wr_chan = m_chan; wr_data = cdata;
      end
      @(negedge clk);
      wr_en = 1'b0;
      if (collide) m_regs[m_chan] = cdata;
      repeat (5) @(negedge clk);
      ADC_CONVST = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic clock_bits(input logic [5:0] word, input int n, output logic [15:0] rx);
      rx = '0;
      for (int i = 0; i < n; i++) begin
         ADC_SDI = (i < 6) ? word[5-i] : 1'($urandom_range(0, 1));
         repeat (HALF) @(negedge clk);
         rx = {rx[14:0], ADC_SDO};
         ADC_SCK = 1'b1;
         repeat (HALF) @(negedge clk);
         ADC_SCK = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      if (n >= 6) begin
         m_chan = {word[3], word[2], word[4]};
         m_uni  = word[1];
      end
   endtask

   task automatic finish_frame(input string tag, input logic [11:0] got);
      if (exp_q.size() == 0) check({tag, "_queue"}, 32'd0, 32'd1);
      else check(tag, {20'd0, got}, {20'd0, exp_q.pop_front()});
   endtask

   initial begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_chan = '0;
      m_uni  = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_sdo", {31'd0, ADC_SDO}, 32'd0);
      check("rst_chan", {29'd0, cfg_chan}, 32'd0);
      check("rst_uni", {31'd0, cfg_uni}, 32'd1);
      check("rst_done", {31'd0, frame_done}, 32'd0);

      write_reg(3'd0, 12'hA5C);
      d0 = done_cnt;
      start_frame(1'b1, 1'b0, 12'h0);
      clock_bits(6'b100010, 12, bits);
      finish_frame("t1_data", bits[11:0]);
      check("t1_const", {20'd0, bits[11:0]}, 32'hA5C);
      check("t1_chan", {29'd0, cfg_chan}, 32'd0);
      check("t1_done", done_cnt - d0, 32'd1);
      check("t1_sdo_idle", {31'd0, ADC_SDO}, 32'd0);

      write_reg(3'd5, 12'h123);
      start_frame(1'b1, 1'b0, 12'h0);
      clock_bits(6'b111010, 12, bits);
      finish_frame("t2_f1_prev_cfg", bits[11:0]);
      check("t2_chan", {29'd0, cfg_chan}, 32'd5);
      start_frame(1'b1, 1'b0, 12'h0);
      clock_bits(6'b111010, 12, bits);
      finish_frame("t2_f2_chan5", bits[11:0]);
      check("t2_const", {20'd0, bits[11:0]}, 32'h123);

      d0 = done_cnt;
      start_frame(1'b0, 1'b0, 12'h0);
      clock_bits(6'b100010, 3, bits);
      start_frame(1'b1, 1'b0, 12'h0);
      check("t3_chan_kept", {29'd0, cfg_chan}, 32'd5);
      clock_bits(6'b111010, 12, bits);
      finish_frame("t3_reload", bits[11:0]);
      check("t3_done", done_cnt - d0, 32'd1);

      write_reg(3'd5, 12'h001);
      start_frame(1'b1, 1'b1, 12'hFFF);
      clock_bits(6'b111010, 12, bits);
      finish_frame("t4_old", bits[11:0]);
      check("t4_old_const", {20'd0, bits[11:0]}, 32'h001);
      start_frame(1'b1, 1'b0, 12'h0);
      clock_bits(6'b111010, 12, bits);
      finish_frame("t4_new", bits[11:0]);

      d0 = done_cnt;
      start_frame(1'b1, 1'b0, 12'h0);
      clock_bits(6'b100010, 16, bits);
      finish_frame("t5_data", bits[15:4]);
      check("t5_tail", {28'd0, bits[3:0]}, 32'd0);
      check("t5_chan", {29'd0, cfg_chan}, 32'd0);
      check("t5_uni", {31'd0, cfg_uni}, 32'd1);
      check("t5_done", done_cnt - d0, 32'd1);

      write_reg(3'd0, 12'h800);
      start_frame(1'b1, 1'b0, 12'h0);
      clock_bits(6'b100000, 12, bits);
      finish_frame("t6_uni_frame", bits[11:0]);
      check("t6_uni", {31'd0, cfg_uni}, 32'd0);
      start_frame(1'b1, 1'b0, 12'h0);
      clock_bits(6'b100010, 12, bits);
      finish_frame("t6_bipolar", bits[11:0]);
      check("t6_const", {20'd0, bits[11:0]}, {20'd0, BIP_EXP});

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("t7_rst_chan", {29'd0, cfg_chan}, 32'd0);
      check("t7_rst_uni", {31'd0, cfg_uni}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
